// File: rtl/mfp_int_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : mfp_int_ctrl_if
//  Purpose  : Register-port bundle between the AHB-Lite GPIO decoder (master)
//             and the mfp_int_ctrl interrupt controller (slave).
//  Signals  : reg_we    - register write strobe
//             reg_re    - register read strobe
//             reg_addr  - register select (0 PENDING, 1 ENABLE, 2 MODE, 3 POL)
//             reg_wdata - write data, one bit per interrupt source
//             reg_rdata - registered read data
//  Revision : 1.0 - initial release
// ============================================================================
interface mfp_int_ctrl_if #(
    parameter int N_SRC = 8
) ();
    logic             reg_we;
    logic             reg_re;
    logic [1:0]       reg_addr;
    logic [N_SRC-1:0] reg_wdata;
    logic [N_SRC-1:0] reg_rdata;

    modport master (
        output reg_we, reg_re, reg_addr, reg_wdata,
        input  reg_rdata
    );

    modport slave (
        input  reg_we, reg_re, reg_addr, reg_wdata,
        output reg_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mfp_int_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mfp_int_ctrl
//  Purpose  : Per-source interrupt controller feeding the m14k SI_Int pins.
//             Synchronises raw sources, applies polarity, detects rising
//             edges or follows levels, latches pending, masks with ENABLE and
//             supports write-1-to-clear with a one-cycle acknowledge pulse.
//  Ports    : HCLK      - system/bus clock
//             SI_Reset  - synchronous active-high reset
//             src_in    - raw interrupt sources
//             bus       - register port (mfp_int_ctrl_if.slave)
//             irq       - pending & enable, registered
//             irq_any   - OR of irq
//             int_ack   - one-cycle acknowledge per source
//  Option   : define MFP_INT_EIC_EN to add eic_ack / eic_vector / eic_valid
//             for External Interrupt Controller mode (fixed priority, bit 0
//             highest, vector = index + 1, 0 when idle).
//  Params   : N_SRC (1..32), SYNC_STAGES (0 = inputs already synchronous)
//  Revision : 1.0 - initial release
// ============================================================================
module mfp_int_ctrl #(
    parameter int N_SRC       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic             HCLK,
    input  wire logic             SI_Reset,
    input  wire logic [N_SRC-1:0] src_in,
    mfp_int_ctrl_if.slave         bus,
    output logic      [N_SRC-1:0] irq,
    output logic                  irq_any,
    output logic      [N_SRC-1:0] int_ack
`ifdef MFP_INT_EIC_EN
    ,
    input  wire logic             eic_ack,
    output logic      [5:0]       eic_vector,
    output logic                  eic_valid
`endif
);

    localparam logic [1:0] c_ADDR_PENDING = 2'd0;
    localparam logic [1:0] c_ADDR_ENABLE  = 2'd1;
    localparam logic [1:0] c_ADDR_MODE    = 2'd2;
    localparam logic [1:0] c_ADDR_POL     = 2'd3;

    logic [N_SRC-1:0] w_src_sync;
    logic [N_SRC-1:0] w_act;
    logic [N_SRC-1:0] w_act_reload;
    logic [N_SRC-1:0] w_new_pol;
    logic [N_SRC-1:0] w_cfg_chg;
    logic [N_SRC-1:0] w_set;
    logic [N_SRC-1:0] w_clr_req;
    logic [N_SRC-1:0] w_clr;
    logic [N_SRC-1:0] w_w1c;
    logic [N_SRC-1:0] w_pend_next;
    logic [N_SRC-1:0] w_rd_mux;
    logic             w_wr_pend;
    logic             w_wr_en;
    logic             w_wr_mode;
    logic             w_wr_pol;

    logic [N_SRC-1:0] r_pending;
    logic [N_SRC-1:0] r_enable;
    logic [N_SRC-1:0] r_mode;
    logic [N_SRC-1:0] r_pol;
    logic [N_SRC-1:0] r_act_prev;
    logic [N_SRC-1:0] r_irq;
    logic             r_irq_any;
    logic [N_SRC-1:0] r_int_ack;
    logic [N_SRC-1:0] r_rdata;

    // ------------------------------------------------------------------------
    // Input synchroniser. While in reset every stage captures the live input
    // so the edge history seeded during reset matches what the chain will
    // present after release (no spurious edge from an already-active source).
    // ------------------------------------------------------------------------
    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [N_SRC-1:0] r_stage [SYNC_STAGES];

            always_ff @(posedge HCLK) begin
                if (SI_Reset) begin
                    for (int s = 0; s < SYNC_STAGES; s++) begin
                        r_stage[s] <= src_in;
                    end
                end else begin
                    r_stage[0] <= src_in;
                    for (int s = 1; s < SYNC_STAGES; s++) begin
                        r_stage[s] <= r_stage[s-1];
                    end
                end
            end

            assign w_src_sync = r_stage[SYNC_STAGES-1];
        end else begin : g_nosync
            assign w_src_sync = src_in;
        end
    endgenerate

    assign w_act = w_src_sync ^ r_pol;

    // ------------------------------------------------------------------------
    // Register-port decode
    // ------------------------------------------------------------------------
    assign w_wr_pend = bus.reg_we && (bus.reg_addr == c_ADDR_PENDING);
    assign w_wr_en   = bus.reg_we && (bus.reg_addr == c_ADDR_ENABLE);
    assign w_wr_mode = bus.reg_we && (bus.reg_addr == c_ADDR_MODE);
    assign w_wr_pol  = bus.reg_we && (bus.reg_addr == c_ADDR_POL);

    // Bits whose MODE or POL is being changed lose their pending state and
    // get their edge history reloaded under the new polarity.
    assign w_cfg_chg    = (w_wr_mode ? (r_mode ^ bus.reg_wdata) : '0)
                        | (w_wr_pol  ? (r_pol  ^ bus.reg_wdata) : '0);
    assign w_new_pol    = w_wr_pol ? bus.reg_wdata : r_pol;
    assign w_act_reload = w_src_sync ^ w_new_pol;

    assign w_w1c = w_wr_pend ? bus.reg_wdata : '0;

`ifdef MFP_INT_EIC_EN
    logic [5:0]       r_eic_vector;
    logic             r_eic_valid;
    logic [5:0]       w_eic_vec_next;
    logic [N_SRC-1:0] w_eic_clr;

    // Lowest-numbered asserted irq wins: scan downwards so the last hit
    // is the lowest index.
    always_comb begin
        w_eic_vec_next = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (r_irq[i]) begin
                w_eic_vec_next = 6'(i + 1);
            end
        end
    end

    // Acknowledge targets the source whose vector is currently presented.
    always_comb begin
        w_eic_clr = '0;
        if (eic_ack && r_eic_valid) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (r_eic_vector == 6'(i + 1)) begin
                    w_eic_clr[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (SI_Reset) begin
            r_eic_vector <= '0;
            r_eic_valid  <= 1'b0;
        end else begin
            r_eic_vector <= w_eic_vec_next;
            r_eic_valid  <= |r_irq;
        end
    end

    assign eic_vector = r_eic_vector;
    assign eic_valid  = r_eic_valid;
    assign w_clr_req  = w_w1c | w_eic_clr;
`else
    assign w_clr_req  = w_w1c;
`endif

    // Software clears only ever act on edge-mode bits.
    assign w_set = r_mode & w_act & ~r_act_prev;
    assign w_clr = w_clr_req & r_mode;

    // Edge bits: set beats clear. Level bits: follow act. Reconfigured bits: 0.
    assign w_pend_next = ((r_mode & (w_set | (r_pending & ~w_clr)))
                       | (~r_mode & w_act)) & ~w_cfg_chg;

    always_comb begin
        case (bus.reg_addr)
            c_ADDR_PENDING: w_rd_mux = r_pending;
            c_ADDR_ENABLE:  w_rd_mux = r_enable;
            c_ADDR_MODE:    w_rd_mux = r_mode;
            default:        w_rd_mux = r_pol;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (SI_Reset) begin
            r_pending  <= '0;
            r_enable   <= '0;
            r_mode     <= '0;
            r_pol      <= '0;
            // Polarity is 0 out of reset, so the raw synchronised sample is
            // the polarity-adjusted history.
            r_act_prev <= w_src_sync;
            r_irq      <= '0;
            r_irq_any  <= 1'b0;
            r_int_ack  <= '0;
            r_rdata    <= '0;
        end else begin
            r_act_prev <= (w_act & ~w_cfg_chg) | (w_act_reload & w_cfg_chg);
            r_pending  <= w_pend_next;
            r_int_ack  <= w_clr & r_pending & ~w_set & ~w_cfg_chg;
            r_irq      <= r_pending & r_enable;
            r_irq_any  <= |(r_pending & r_enable);
            if (w_wr_en) begin
                r_enable <= bus.reg_wdata;
            end
            if (w_wr_mode) begin
                r_mode <= bus.reg_wdata;
            end
            if (w_wr_pol) begin
                r_pol <= bus.reg_wdata;
            end
            // Read mux sees pre-write register contents.
            if (bus.reg_re) begin
                r_rdata <= w_rd_mux;
            end
        end
    end

    assign irq           = r_irq;
    assign irq_any       = r_irq_any;
    assign int_ack       = r_int_ack;
    assign bus.reg_rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mfp_int_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mfp_int_ctrl
//  Purpose  : Self-checking bench for mfp_int_ctrl. Stimulus pushes expected
//             values into queues; a monitor on the falling clock edge pops
//             timed expectations and register-read results and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mfp_int_ctrl;

    localparam int N  = 8;
    localparam int SS = 2;

    localparam int c_SIG_IRQ   = 0;
    localparam int c_SIG_ANY   = 1;
    localparam int c_SIG_ACK   = 2;
    localparam int c_SIG_VEC   = 3;
    localparam int c_SIG_VALID = 4;
    localparam int c_SIG_RDATA = 5;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    typedef struct {
        logic [31:0] val;
        string       name;
    } rd_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] src_in;
    logic [N-1:0] irq;
    logic         irq_any;
    logic [N-1:0] int_ack;
`ifdef MFP_INT_EIC_EN
    logic         eic_ack;
    logic [5:0]   eic_vector;
    logic         eic_valid;
`endif

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t ev_q[$];
    rd_t  rd_q[$];

    mfp_int_ctrl_if #(.N_SRC(N)) bus ();

    mfp_int_ctrl #(
        .N_SRC       (N),
        .SYNC_STAGES (SS)
    ) dut (
        .HCLK       (clk),
        .SI_Reset   (rst),
        .src_in     (src_in),
        .bus        (bus),
        .irq        (irq),
        .irq_any    (irq_any),
        .int_ack    (int_ack)
`ifdef MFP_INT_EIC_EN
        ,
        .eic_ack    (eic_ack),
        .eic_vector (eic_vector),
        .eic_valid  (eic_valid)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    function automatic logic [31:0] sample(input int sig);
        logic [31:0] v;
        v = '0;
        case (sig)
            c_SIG_IRQ:   v = 32'(irq);
            c_SIG_ANY:   v = 32'(irq_any);
            c_SIG_ACK:   v = 32'(int_ack);
`ifdef MFP_INT_EIC_EN
            c_SIG_VEC:   v = 32'(eic_vector);
            c_SIG_VALID: v = 32'(eic_valid);
`endif
            c_SIG_RDATA: v = 32'(bus.reg_rdata);
            default:     v = '0;
        endcase
        return v;
    endfunction

    initial begin
        logic        prev_re;
        exp_t        e;
        rd_t         r;
        logic [31:0] act;
        prev_re = 1'b0;
        forever begin
            @(negedge clk);
            while (ev_q.size() > 0 && ev_q[0].cyc <= cyc) begin
                e   = ev_q.pop_front();
                act = sample(e.sig);
                n_cmp++;
                if (act !== e.val) begin
                    n_bad++;
                    $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                             e.name, act, e.val, cyc);
                end
            end
            if (prev_re) begin
                n_cmp++;
                if (rd_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_read: got 0x%0h expected no read (cycle %0d)",
                             bus.reg_rdata, cyc);
                end else begin
                    r = rd_q.pop_front();
                    if (32'(bus.reg_rdata) !== r.val) begin
                        n_bad++;
                        $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                                 r.name, bus.reg_rdata, r.val, cyc);
                    end
                end
            end
            prev_re = bus.reg_re;
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expect signal `sig` to equal `v` after the d-th upcoming clock edge.
    function automatic void expect_at(input int d, input int sig,
                                      input logic [31:0] v, input string nm);
        exp_t e;
        int   idx;
        e.cyc  = cyc + d;
        e.sig  = sig;
        e.val  = v;
        e.name = nm;
        idx    = ev_q.size();
        for (int i = 0; i < ev_q.size(); i++) begin
            if (ev_q[i].cyc > e.cyc) begin
                idx = i;
                break;
            end
        end
        ev_q.insert(idx, e);
    endfunction

    task automatic bus_op(input logic we, input logic re, input logic [1:0] addr,
                          input logic [N-1:0] wdata, input logic [31:0] exp_rd,
                          input string nm);
        rd_t r;
        if (re) begin
            r.val  = exp_rd;
            r.name = nm;
            rd_q.push_back(r);
        end
        bus.reg_we    = we;
        bus.reg_re    = re;
        bus.reg_addr  = addr;
        bus.reg_wdata = wdata;
        tick(1);
        bus.reg_we    = 1'b0;
        bus.reg_re    = 1'b0;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [N-1:0] data);
        bus_op(1'b1, 1'b0, addr, data, 32'h0, "");
    endtask

    task automatic rd(input logic [1:0] addr, input logic [31:0] exp_rd, input string nm);
        bus_op(1'b0, 1'b1, addr, '0, exp_rd, nm);
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        rst           = 1'b1;
        src_in        = 8'h08;
        bus.reg_we    = 1'b0;
        bus.reg_re    = 1'b0;
        bus.reg_addr  = 2'd0;
        bus.reg_wdata = '0;
`ifdef MFP_INT_EIC_EN
        eic_ack       = 1'b0;
`endif

        // Reset state, with src_in[3] already high.
        expect_at(2, c_SIG_IRQ,   32'h0, "rst_irq");
        expect_at(2, c_SIG_ANY,   32'h0, "rst_irq_any");
        expect_at(2, c_SIG_ACK,   32'h0, "rst_int_ack");
        expect_at(2, c_SIG_RDATA, 32'h0, "rst_rdata");
        tick(5);
        rst = 1'b0;
        tick(1);
        for (int i = 1; i <= 20; i++) begin
            expect_at(i, c_SIG_IRQ, 32'h0, "t1_irq_quiet");
        end
        wr(2'd2, 8'hFF);
        wr(2'd1, 8'hFF);
        tick(18);
        rd(2'd0, 32'h00, "t1_pending");
        src_in[3] = 1'b0;
        tick(SS + 2);

        // Rising edge on bit 0: latency, then W1C with acknowledge.
        src_in[0] = 1'b1;
        expect_at(SS + 1, c_SIG_IRQ, 32'h00, "t2_irq_early");
        expect_at(SS + 2, c_SIG_IRQ, 32'h01, "t2_irq_latency");
        expect_at(SS + 2, c_SIG_ANY, 32'h1,  "t2_irq_any");
        tick(SS + 4);
        expect_at(1, c_SIG_ACK, 32'h01, "t2_ack_pulse");
        expect_at(2, c_SIG_ACK, 32'h00, "t2_ack_one_cycle");
        expect_at(2, c_SIG_IRQ, 32'h00, "t2_irq_cleared");
        wr(2'd0, 8'h01);
        tick(3);
        src_in[0] = 1'b0;
        expect_at(1, c_SIG_ACK, 32'h00, "t2_ack_already_clear");
        wr(2'd0, 8'h01);
        tick(2);

        // Level mode on bit 5 with active-low polarity.
        wr(2'd2, 8'hDF);
        wr(2'd3, 8'h20);
        tick(3);
        rd(2'd0, 32'h20, "t3_level_pending");
        expect_at(1, c_SIG_IRQ, 32'h20, "t3_level_irq");
        wr(2'd0, 8'h20);
        tick(1);
        rd(2'd0, 32'h20, "t3_w1c_ignored");
        src_in[5] = 1'b1;
        tick(SS + 2);
        rd(2'd0, 32'h00, "t3_level_released");
        wr(2'd3, 8'h00);
        wr(2'd2, 8'hFF);
        src_in[5] = 1'b0;
        tick(SS + 2);
        rd(2'd0, 32'h00, "t3_reconfig_no_edge");

        // Edge on bit 2 coinciding with W1C of the same bit.
        src_in[2] = 1'b1;
        tick(SS + 3);
        src_in[2] = 1'b0;
        tick(SS + 3);
        rd(2'd0, 32'h04, "t4_pre_pending");
        src_in[2] = 1'b1;
        tick(SS);
        expect_at(1, c_SIG_ACK, 32'h00, "t4_collide_no_ack");
        expect_at(2, c_SIG_ACK, 32'h00, "t4_collide_no_ack2");
        wr(2'd0, 8'h04);
        tick(2);
        rd(2'd0, 32'h04, "t4_set_wins");
        expect_at(1, c_SIG_ACK, 32'h04, "t4_clean_ack");
        wr(2'd0, 8'h04);
        src_in[2] = 1'b0;
        tick(2);
        rd(2'd0, 32'h00, "t4_cleared");

        // Masked source still latches; enabling later raises irq.
        wr(2'd1, 8'h00);
        src_in[1] = 1'b1;
        tick(SS + 3);
        expect_at(1, c_SIG_IRQ, 32'h00, "t5_masked_irq");
        rd(2'd0, 32'h02, "t5_masked_pending");
        expect_at(1, c_SIG_IRQ, 32'h00, "t5_enable_irq_wait");
        expect_at(2, c_SIG_IRQ, 32'h02, "t5_enable_irq");
        expect_at(2, c_SIG_ANY, 32'h1,  "t5_enable_irq_any");
        wr(2'd1, 8'h02);
        tick(2);
        rd(2'd2, 32'hFF, "t5_mode_rd");
        rd(2'd3, 32'h00, "t5_pol_rd");
        bus_op(1'b1, 1'b1, 2'd1, 8'hFF, 32'h02, "t5_rd_pre_write");
        rd(2'd1, 32'hFF, "t5_enable_rd");
        src_in[1] = 1'b0;
        wr(2'd0, 8'h02);
        tick(3);

`ifdef MFP_INT_EIC_EN
        // EIC vectoring: bits 6 and 2 pending, bit 2 has priority.
        src_in[6] = 1'b1;
        src_in[2] = 1'b1;
        tick(SS + 5);
        expect_at(1, c_SIG_VEC,   32'd3, "t6_vec_first");
        expect_at(1, c_SIG_VALID, 32'h1, "t6_valid");
        tick(1);
        eic_ack = 1'b1;
        expect_at(1, c_SIG_ACK, 32'h04, "t6_eic_int_ack");
        expect_at(2, c_SIG_IRQ, 32'h40, "t6_irq_after_ack");
        expect_at(3, c_SIG_VEC, 32'd7,  "t6_vec_second");
        tick(1);
        eic_ack = 1'b0;
        tick(4);
        src_in = '0;
        wr(2'd0, 8'h40);
        tick(4);
        expect_at(1, c_SIG_VALID, 32'h0, "t6_valid_idle");
        expect_at(1, c_SIG_VEC,   32'd0, "t6_vec_idle");
        tick(2);
`endif

        // Reset mid-operation, with a W1C in the same cycle.
        src_in[7] = 1'b1;
        tick(SS + 4);
        src_in[7] = 1'b0;
        tick(SS + 2);
        expect_at(1, c_SIG_IRQ, 32'h80, "t7_pre_reset_irq");
        tick(1);
        expect_at(1, c_SIG_ACK, 32'h00, "t7_reset_no_ack");
        expect_at(2, c_SIG_ACK, 32'h00, "t7_reset_no_ack2");
        expect_at(1, c_SIG_IRQ, 32'h00, "t7_reset_irq");
        expect_at(1, c_SIG_ANY, 32'h0,  "t7_reset_irq_any");
        rst = 1'b1;
        wr(2'd0, 8'h80);
        rst = 1'b0;
        tick(1);
        rd(2'd0, 32'h00, "t7_pending_rst");
        rd(2'd1, 32'h00, "t7_enable_rst");
        rd(2'd2, 32'h00, "t7_mode_rst");

        // Drain outstanding expectations within a bounded window.
        for (int i = 0; i < 100 && (ev_q.size() > 0 || rd_q.size() > 0); i++) begin
            tick(1);
        end
        tick(2);
        while (ev_q.size() > 0) begin
            exp_t e;
            e = ev_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got nothing expected 0x%0h (never checked)", e.name, e.val);
        end
        while (rd_q.size() > 0) begin
            rd_t r;
            r = rd_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got no read data expected 0x%0h", r.name, r.val);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
